// File: rtl/dpram_port_arbiter_pkg.sv
// Shared defaults and width helpers for the dual-port RAM port arbiter.
package dpram_port_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 8;

  // Bits needed to index 'depth' entries; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant. A requester granted this
// cycle is masked, so a request held through its grant cycle is not granted twice.
module rr_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = addr_width(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          win_vld,
  output logic [IW-1:0] win_idx
);

  logic [N-1:0]  gnt_d, gnt_q;
  logic [IW-1:0] ptr_d, ptr_q;
  logic [N-1:0]  eligible;
  logic [IW-1:0] cand;

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    eligible = req & ~gnt_q;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    // Walk offsets from farthest to nearest so the index closest to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    if (win_vld) begin
      gnt_d[win_idx] = 1'b1;
      ptr_d          = IW'((int'(win_idx) + 1) % N);
    end
  end

  // NOTE: state flops use non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port RAM between NREQ writers and NREQ readers: one round-robin
// arbiter per RAM port, registered RAM controls, one-hot read-data valid strobe.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       wr_req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       wr_gnt,
  input  logic [NREQ-1:0]       rd_req,
  input  logic [NREQ*AW-1:0]    rd_addr,
  output logic [NREQ-1:0]       rd_gnt,
  output logic [NREQ-1:0]       rd_vld,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  ram_wenc,
  output logic [AW-1:0]         ram_waddr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_renc,
  output logic [AW-1:0]         ram_raddr,
  input  logic [WIDTH-1:0]      ram_rdata
);

  localparam int IW = addr_width(NREQ);

  logic          wr_win_vld, rd_win_vld;
  logic [IW-1:0] wr_win_idx, rd_win_idx;

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .win_vld (wr_win_vld),
    .win_idx (wr_win_idx)
  );

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .win_vld (rd_win_vld),
    .win_idx (rd_win_idx)
  );

  logic             ram_wenc_d, ram_wenc_q;
  logic [AW-1:0]    ram_waddr_d, ram_waddr_q;
  logic [WIDTH-1:0] ram_wdata_d, ram_wdata_q;
  logic             ram_renc_d, ram_renc_q;
  logic [AW-1:0]    ram_raddr_d, ram_raddr_q;
  logic [NREQ-1:0]  rd_vld_d, rd_vld_q;

  // Address/data are steered by the same winner index the arbiters register as gnt,
  // so the RAM command and its grant always appear in the same cycle.
  always_comb begin
    ram_wenc_d  = wr_win_vld;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    ram_renc_d  = rd_win_vld;
    ram_raddr_d = ram_raddr_q;
    rd_vld_d    = rd_gnt;
    if (wr_win_vld) begin
      ram_waddr_d = wr_addr[int'(wr_win_idx) * AW +: AW];
      ram_wdata_d = wr_data[int'(wr_win_idx) * WIDTH +: WIDTH];
    end
    if (rd_win_vld) begin
      ram_raddr_d = rd_addr[int'(rd_win_idx) * AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_wenc_q  <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_renc_q  <= 1'b0;
      ram_raddr_q <= '0;
      rd_vld_q    <= '0;
    end else begin
      ram_wenc_q  <= ram_wenc_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_renc_q  <= ram_renc_d;
      ram_raddr_q <= ram_raddr_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  assign ram_wenc  = ram_wenc_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_renc  = ram_renc_q;
  assign ram_raddr = ram_raddr_q;
  assign rd_vld    = rd_vld_q;
  assign rd_data   = ram_rdata;

endmodule
